// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } dm_arb_state_e;

  localparam int unsigned BurstMaxLen = 8;
  localparam int unsigned BeatCntW    = $clog2(BurstMaxLen);

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU, DMA and data-memory signal bundle; the arbiter takes the slave view.
interface dm_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);
  import dm_arb_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;

  logic                dma_req;
  logic                dma_we;
  logic [ADDR_W-1:0]   dma_addr;
  logic [BeatCntW-1:0] dma_len;
  logic [31:0]         dma_wdata;
  logic                dma_ack;
  logic [31:0]         dma_rdata;
  logic                dma_done;

  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_we;
  logic [31:0]       dm_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    output dma_ack, dma_rdata, dma_done,
    output dm_addr, dm_wdata, dm_we,
    input  dm_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
    input  dma_ack, dma_rdata, dma_done,
    input  dm_addr, dm_wdata, dm_we,
    output dm_rdata
  );

endinterface

// File: rtl/dm_burst_counter.sv
// DMA burst beat counter and word-aligned address generator.
module dm_burst_counter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [ADDR_W-1:0]   base_i,
  input  logic [BeatCntW-1:0] len_i,
  input  logic                advance_i,
  output logic [ADDR_W-1:0]   addr_o,
  output logic                last_o
);

  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BeatCntW-1:0] beat_q, beat_d;
  logic [BeatCntW-1:0] len_q, len_d;

  always_comb begin
    addr_d = addr_q;
    beat_d = beat_q;
    len_d  = len_q;
    if (load_i) begin
      addr_d = {base_i[ADDR_W-1:2], 2'b00};
      beat_d = '0;
      len_d  = len_i;
    end else if (advance_i) begin
      // Wraps naturally modulo 2^ADDR_W.
      addr_d = addr_q + ADDR_W'(4);
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      beat_q <= '0;
      len_q  <= '0;
    end else begin
      addr_q <= addr_d;
      beat_q <= beat_d;
      len_q  <= len_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (beat_q == len_q);

endmodule

// File: rtl/dm_arbiter.sv
// CPU/DMA data-memory arbiter with DMA bursts and CPU starvation relief.
// Define DM_ARB_RR_EN for round-robin arbitration in IDLE instead of CPU priority.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic          clk,
  input  logic          reset,
  dm_arbiter_if.slave   bus
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  dm_arb_state_e      state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic               done_q, done_d;
  logic               we_q, we_d;
`ifdef DM_ARB_RR_EN
  logic               last_cpu_q, last_cpu_d;
`endif

  logic              cpu_grant, dma_grant, beat_en, cpu_slot, burst_last;
  logic [ADDR_W-1:0] burst_addr;

  dm_burst_counter #(
    .ADDR_W (ADDR_W)
  ) u_burst_counter (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (dma_grant),
    .base_i    (bus.dma_addr),
    .len_i     (bus.dma_len),
    .advance_i (beat_en),
    .addr_o    (burst_addr),
    .last_o    (burst_last)
  );

  // Grant decode shared by next-state and output logic.
  always_comb begin
    cpu_slot  = (32'(starve_q) >= STARVE_LIMIT);
    cpu_grant = 1'b0;
    dma_grant = 1'b0;
    beat_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
`ifdef DM_ARB_RR_EN
        if (bus.cpu_req && bus.dma_req) begin
          cpu_grant = ~last_cpu_q;
          dma_grant = last_cpu_q;
        end else begin
          cpu_grant = bus.cpu_req;
          dma_grant = bus.dma_req;
        end
`else
        cpu_grant = bus.cpu_req;
        dma_grant = bus.dma_req & ~bus.cpu_req;
`endif
      end
      StBurst: begin
        cpu_grant = bus.cpu_req & cpu_slot;
        beat_en   = ~cpu_grant;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    we_d     = we_q;
    starve_d = '0;
    unique case (state_q)
      StIdle: begin
        if (dma_grant) begin
          state_d = StBurst;
          we_d    = bus.dma_we;
        end
      end
      StBurst: begin
        if (beat_en && burst_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.cpu_req && !cpu_grant) begin
      starve_d = (state_q == StBurst) ? starve_q + 1'b1 : starve_q;
    end
  end

`ifdef DM_ARB_RR_EN
  always_comb begin
    last_cpu_d = last_cpu_q;
    if (cpu_grant) begin
      last_cpu_d = 1'b1;
    end else if (dma_grant) begin
      last_cpu_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      starve_q   <= '0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
`ifdef DM_ARB_RR_EN
      last_cpu_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      done_q     <= done_d;
      we_q       <= we_d;
`ifdef DM_ARB_RR_EN
      last_cpu_q <= last_cpu_d;
`endif
    end
  end

  // Everything is forced quiet while reset is held low.
  always_comb begin
    bus.cpu_rdata = '0;
    bus.cpu_stall = 1'b0;
    bus.dma_ack   = 1'b0;
    bus.dma_rdata = '0;
    bus.dma_done  = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.dm_we     = 1'b0;
    if (reset) begin
      bus.cpu_stall = bus.cpu_req & ~cpu_grant;
      bus.dma_done  = done_q;
      if (cpu_grant) begin
        bus.dm_addr   = bus.cpu_addr;
        bus.dm_wdata  = bus.cpu_wdata;
        bus.dm_we     = bus.cpu_we;
        bus.cpu_rdata = bus.dm_rdata;
      end else if (beat_en) begin
        bus.dm_addr   = burst_addr;
        bus.dm_wdata  = bus.dma_wdata;
        bus.dm_we     = we_q;
        bus.dma_rdata = bus.dm_rdata;
        bus.dma_ack   = 1'b1;
      end
    end
  end

endmodule
